// File: rtl/reconfig_filt_pkg.sv
// rtl/reconfig_filt_pkg.sv - shared types and helpers for the reconfigurable FIR/IIR MAC filter
package reconfig_filt_pkg;

  typedef enum logic {MODE_FIR = 1'b0, MODE_IIR = 1'b1} mode_e;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_e;

  function automatic int acc_w(input int dw, input int cw, input int nb, input int na);
    return dw + cw + $clog2(nb + na);
  endfunction

  function automatic int addr_w(input int nb, input int na);
    return $clog2((nb > na + 1) ? nb : na + 1);
  endfunction

  // Clamp to the signed range of a dw-bit sample.
  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/reconfig_coef_bank.sv
// rtl/reconfig_coef_bank.sv - b/a coefficient registers with write decode and tap-indexed read mux
module reconfig_coef_bank #(
  parameter int COEF_W = 8,
  parameter int N_B    = 4,
  parameter int N_A    = 2,
  parameter int AW     = 2,
  parameter int TW     = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic              i_sel,
  input  logic [AW-1:0]     i_addr,
  input  logic [COEF_W-1:0] i_data,
  input  logic [TW-1:0]     i_tap,
  output logic [COEF_W-1:0] o_coef
);

  logic [COEF_W-1:0] r_b [N_B];
  logic [COEF_W-1:0] r_a [N_A];

  // r_a[k] holds a(k+1); a0 and addresses past either bank never match.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_B; k++) r_b[k] <= (k == 0) ? COEF_W'(1) : '0;
      for (int k = 0; k < N_A; k++) r_a[k] <= '0;
    end else if (i_we) begin
      for (int k = 0; k < N_B; k++)
        if (!i_sel && int'(i_addr) == k) r_b[k] <= i_data;
      for (int k = 0; k < N_A; k++)
        if (i_sel && int'(i_addr) == k + 1) r_a[k] <= i_data;
    end
  end

  always_comb begin
    o_coef = '0;
    for (int k = 0; k < N_B; k++)
      if (int'(i_tap) == k) o_coef = r_b[k];
    for (int k = 0; k < N_A; k++)
      if (int'(i_tap) == N_B + k) o_coef = r_a[k];
  end

endmodule

// File: rtl/reconfig_fir_iir_mac.sv
// rtl/reconfig_fir_iir_mac.sv - direct-form-I FIR/IIR filter with a shared FSM-sequenced MAC
module reconfig_fir_iir_mac
  import reconfig_filt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int N_B    = 4,
  parameter int N_A    = 2,
  parameter int SHIFT  = 0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_mode,
  input  logic                        i_coef_we,
  input  logic                        i_coef_sel,
  input  logic [addr_w(N_B,N_A)-1:0]  i_coef_addr,
  input  logic [COEF_W-1:0]           i_coef_data,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [DATA_W-1:0]           i_in_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DATA_W-1:0]           o_out_data,
  output logic                        o_sat_flag
);

  localparam int ACC_W = acc_w(DATA_W, COEF_W, N_B, N_A);
  localparam int TW    = $clog2(N_B + N_A);
  localparam int PW    = DATA_W + COEF_W;

  state_e                   r_state;
  mode_e                    r_mode;
  logic [TW-1:0]            r_tap;
  logic signed [DATA_W-1:0] r_x [N_B];
  logic signed [DATA_W-1:0] r_y [N_A];
  logic signed [ACC_W-1:0]  r_acc;

  logic [COEF_W-1:0]        w_coef;
  logic signed [DATA_W-1:0] w_sample;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [63:0]       w_shifted;
  logic signed [63:0]       w_sat;
  logic                     w_is_b;
  logic                     w_last;
  logic                     w_accept;

  reconfig_coef_bank #(
    .COEF_W(COEF_W), .N_B(N_B), .N_A(N_A), .AW(addr_w(N_B, N_A)), .TW(TW)
  ) u_coef_bank (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_we    (i_coef_we && r_state == IDLE),
    .i_sel   (i_coef_sel),
    .i_addr  (i_coef_addr),
    .i_data  (i_coef_data),
    .i_tap   (r_tap),
    .o_coef  (w_coef)
  );

  // A coefficient write in IDLE takes priority over a pending sample.
  assign o_in_ready  = (r_state == IDLE) && !i_coef_we;
  assign o_out_valid = (r_state == OUT);
  assign w_accept    = o_in_ready && i_in_valid;

  // Taps 0..N_B-1 read x history, the remaining taps read y history.
  always_comb begin
    w_sample = '0;
    for (int k = 0; k < N_B; k++)
      if (int'(r_tap) == k) w_sample = r_x[k];
    for (int k = 0; k < N_A; k++)
      if (int'(r_tap) == N_B + k) w_sample = r_y[k];
  end

  assign w_is_b     = int'(r_tap) < N_B;
  assign w_prod     = $signed(w_coef) * w_sample;
  assign w_acc_next = w_is_b ? r_acc + ACC_W'(w_prod) : r_acc - ACC_W'(w_prod);
  assign w_last     = int'(r_tap) == ((r_mode == MODE_IIR) ? N_B + N_A - 1 : N_B - 1);
  assign w_shifted  = 64'(w_acc_next >>> SHIFT);
  assign w_sat      = sat_val(w_shifted, DATA_W);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_mode     <= MODE_FIR;
      r_tap      <= '0;
      r_acc      <= '0;
      o_out_data <= '0;
      o_sat_flag <= 1'b0;
      for (int k = 0; k < N_B; k++) r_x[k] <= '0;
      for (int k = 0; k < N_A; k++) r_y[k] <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_x[0] <= i_in_data;
          for (int k = 1; k < N_B; k++) r_x[k] <= r_x[k-1];
          r_mode <= mode_e'(i_mode);
          if (mode_e'(i_mode) != r_mode)
            for (int k = 0; k < N_A; k++) r_y[k] <= '0;
          r_tap   <= '0;
          r_acc   <= '0;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_tap <= r_tap + TW'(1);
          if (w_last) begin
            o_out_data <= w_sat[DATA_W-1:0];
            o_sat_flag <= (w_sat != w_shifted);
            // Feedback uses the clipped output so the loop stays bounded.
            if (r_mode == MODE_IIR) begin
              r_y[0] <= w_sat[DATA_W-1:0];
              for (int k = 1; k < N_A; k++) r_y[k] <= r_y[k-1];
            end
            r_state <= OUT;
          end
        end
        OUT: if (i_out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconfig_fir_iir_mac.sv
// tb/tb_reconfig_fir_iir_mac.sv - self-checking bench for reconfig_fir_iir_mac
module tb_reconfig_fir_iir_mac;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       coef_we = 1'b0;
  logic       coef_sel = 1'b0;
  logic [1:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       sat_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {int y; bit s;} exp_t;
  exp_t exp_q[$];

  int mb[4];
  int ma[2];
  int mx[4];
  int my[2];
  bit mmode;

  reconfig_fir_iir_mac dut (
    .i_clock(clk), .i_reset(rst), .i_mode(mode),
    .i_coef_we(coef_we), .i_coef_sel(coef_sel), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin mb[k] = (k == 0) ? 1 : 0; mx[k] = 0; end
    for (int k = 0; k < 2; k++) begin ma[k] = 0; my[k] = 0; end
    mmode = 0;
  endtask

  task automatic model_accept(input int x, input bit m);
    int acc;
    exp_t e;
    if (m != mmode) begin my[0] = 0; my[1] = 0; end
    mmode = m;
    for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += mb[k] * mx[k];
    if (m) for (int k = 0; k < 2; k++) acc -= ma[k] * my[k];
    e.s = 0;
    if (acc > 127) begin acc = 127; e.s = 1; end
    else if (acc < -128) begin acc = -128; e.s = 1; end
    e.y = acc;
    if (m) begin my[1] = my[0]; my[0] = acc; end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid actual data %0d required no output", $signed(out_data));
      end else begin
        if (int'($signed(out_data)) != exp_q[0].y || sat_flag != exp_q[0].s) begin
          errors++;
          $display("FAIL model_out actual %0d/%0b required %0d/%0b",
                   $signed(out_data), sat_flag, exp_q[0].y, exp_q[0].s);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wcoef(input bit sel, input int addr, input int data, input bit applies);
    @(posedge clk); #1;
    coef_we = 1; coef_sel = sel; coef_addr = 2'(addr); coef_data = 8'(data);
    @(posedge clk); #1;
    coef_we = 0;
    if (applies) begin
      if (sel) ma[addr-1] = data; else mb[addr] = data;
    end
  endtask

  // wr: 0 none, 1 b0 write together with in_valid in IDLE, 2 b0 write during MAC
  task automatic send(input int x, input bit m, input int exp_y, input bit exp_s,
                      input int hold, input int wr, input int wr_data);
    int lat;
    int n;
    bit ok;
    int k_taps;
    k_taps = m ? 6 : 4;
    @(posedge clk); #1;
    in_valid = 1; in_data = 8'(x); mode = m;
    if (hold > 0) out_ready = 0;
    if (wr == 1) begin
      coef_we = 1; coef_sel = 0; coef_addr = 0; coef_data = 8'(wr_data);
      @(negedge clk);
      check("in_ready_during_write", int'(in_ready), 0);
      @(posedge clk); #1;
      coef_we = 0;
      mb[0] = wr_data;
    end
    ok = 0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (in_ready) ok = 1; else n++;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    model_accept(x, m);
    @(posedge clk); #1;
    in_valid = 0;
    if (wr == 2) begin
      coef_we = 1; coef_sel = 0; coef_addr = 0; coef_data = 8'(wr_data);
    end
    lat = 1; ok = 0;
    while (!ok && lat < 40) begin
      @(negedge clk);
      if (out_valid) ok = 1;
      else begin @(posedge clk); #1; coef_we = 0; lat++; end
    end
    coef_we = 0;
    if (!ok) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, k_taps + 1);
    check("out_data_literal", int'($signed(out_data)), exp_y);
    check("sat_flag_literal", int'(sat_flag), int'(exp_s));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_data", int'($signed(out_data)), exp_y);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
    end
    @(negedge clk);
    check("in_ready_after_out", int'(in_ready), 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_sat_flag", int'(sat_flag), 0);

    // FIR impulse response
    wcoef(0, 0, 2, 1); wcoef(0, 1, 1, 1); wcoef(0, 2, 3, 1); wcoef(0, 3, 4, 1);
    send(1, 0, 2, 0, 0, 0, 0);
    send(0, 0, 1, 0, 0, 0, 0);
    send(0, 0, 3, 0, 0, 0, 0);
    send(0, 0, 4, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 0, 0);

    // IIR running sum
    wcoef(0, 0, 1, 1); wcoef(0, 1, 0, 1); wcoef(0, 2, 0, 1); wcoef(0, 3, 0, 1);
    wcoef(1, 1, -1, 1); wcoef(1, 2, 0, 1);
    send(1, 1, 1, 0, 0, 0, 0);
    send(0, 1, 1, 0, 0, 0, 0);
    send(0, 1, 1, 0, 0, 0, 0);
    send(0, 1, 1, 0, 0, 0, 0);

    // FIR then IIR again: y history must have been cleared
    send(0, 0, 0, 0, 0, 0, 0);
    send(0, 1, 0, 0, 0, 0, 0);

    // a0 and out-of-range writes are dropped
    wcoef(1, 0, 50, 0);
    wcoef(1, 3, 50, 0);
    send(3, 1, 3, 0, 0, 0, 0);
    send(0, 1, 3, 0, 0, 0, 0);
    send(0, 1, 3, 0, 0, 0, 0);

    // Saturation and its boundaries
    wcoef(0, 0, 127, 1);
    send(2, 0, 127, 1, 0, 0, 0);
    send(-2, 0, -128, 1, 0, 0, 0);
    send(1, 0, 127, 0, 0, 0, 0);
    send(-1, 0, -127, 0, 0, 0, 0);

    // Backpressure
    wcoef(0, 0, 1, 1);
    send(9, 0, 9, 0, 10, 0, 0);

    // Write during MAC dropped; write with in_valid wins then sample goes
    send(7, 0, 7, 0, 0, 2, 5);
    send(2, 0, 2, 0, 0, 0, 0);
    send(4, 0, 12, 0, 0, 1, 3);

    // Reset mid-MAC
    @(posedge clk); #1;
    in_valid = 1; in_data = 8'd50; mode = 0;
    @(negedge clk);
    check("pre_reset_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    check("post_reset_out_valid", int'(out_valid), 0);
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_out_data", int'(out_data), 0);
    repeat (8) @(negedge clk);
    send(5, 0, 5, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
